// File: rtl/amm_xfer_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : amm_xfer_sequencer_if
// Description : Command, user-stream, master-control and status signals of the
//               Avalon-MM transfer sequencer, bundled for port connection.
// Revision    : 1.0 - initial release
// ============================================================================
interface amm_xfer_sequencer_if #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int CNTWIDTH     = 16
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_op;
    logic [ADDRESSWIDTH-1:0] cmd_src;
    logic [ADDRESSWIDTH-1:0] cmd_dst;
    logic [CNTWIDTH-1:0]     cmd_words;
    logic                    cmd_fixed;

    logic                    wdata_valid;
    logic                    wdata_ready;
    logic [DATAWIDTH-1:0]    wdata;
    logic                    rdata_valid;
    logic                    rdata_ready;
    logic [DATAWIDTH-1:0]    rdata;

    logic                    rd_fixed_location;
    logic                    rd_go;
    logic                    rd_read_buffer;
    logic [ADDRESSWIDTH-1:0] rd_base;
    logic [ADDRESSWIDTH-1:0] rd_length;
    logic                    rd_done;
    logic                    rd_data_available;
    logic [DATAWIDTH-1:0]    rd_buffer_data;

    logic                    wr_fixed_location;
    logic                    wr_go;
    logic                    wr_write_buffer;
    logic [ADDRESSWIDTH-1:0] wr_base;
    logic [ADDRESSWIDTH-1:0] wr_length;
    logic [DATAWIDTH-1:0]    wr_buffer_data;
    logic                    wr_done;
    logic                    wr_buffer_full;

    logic                    busy;
    logic                    xfer_done;
    logic                    xfer_error;
    logic [CNTWIDTH-1:0]     words_moved;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_words, cmd_fixed,
        input  wdata_valid, wdata, rdata_ready,
        input  rd_done, rd_data_available, rd_buffer_data,
        input  wr_done, wr_buffer_full,
        output cmd_ready, wdata_ready, rdata_valid, rdata,
        output rd_fixed_location, rd_go, rd_read_buffer, rd_base, rd_length,
        output wr_fixed_location, wr_go, wr_write_buffer, wr_base, wr_length, wr_buffer_data,
        output busy, xfer_done, xfer_error, words_moved
    );

    // User logic / master pair side
    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst, cmd_words, cmd_fixed,
        output wdata_valid, wdata, rdata_ready,
        output rd_done, rd_data_available, rd_buffer_data,
        output wr_done, wr_buffer_full,
        input  cmd_ready, wdata_ready, rdata_valid, rdata,
        input  rd_fixed_location, rd_go, rd_read_buffer, rd_base, rd_length,
        input  wr_fixed_location, wr_go, wr_write_buffer, wr_base, wr_length, wr_buffer_data,
        input  busy, xfer_done, xfer_error, words_moved
    );
endinterface
`default_nettype wire

// File: rtl/amm_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : amm_xfer_sequencer
// Description : READ / WRITE / COPY sequencer for the Avalon-MM read/write
//               master pair, with an internal FIFO between source and sink.
//               Optional macro AMM_XFER_FIXED_EN enables fixed-location mode.
// Revision    : 1.0 - initial release
// ============================================================================
module amm_xfer_sequencer #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNTWIDTH     = 16
) (
    input  wire logic              clk,
    input  wire logic              reset,
    amm_xfer_sequencer_if.slave    bus
);
    localparam int c_BPW  = DATAWIDTH / 8;
    localparam int c_PTRW = $clog2(FIFO_DEPTH);

    localparam logic [c_PTRW:0]       c_FULL    = (c_PTRW+1)'(FIFO_DEPTH);
    localparam logic [c_PTRW-1:0]     c_PTR_ONE = c_PTRW'(1);
    localparam logic [c_PTRW:0]       c_CNT_ONE = (c_PTRW+1)'(1);
    localparam logic [CNTWIDTH-1:0]   c_W_ONE   = CNTWIDTH'(1);
    localparam logic [ADDRESSWIDTH-1:0] c_BPW_A = ADDRESSWIDTH'(c_BPW);

    localparam logic [1:0] c_OP_READ  = 2'b00;
    localparam logic [1:0] c_OP_WRITE = 2'b01;
    localparam logic [1:0] c_OP_COPY  = 2'b10;
    localparam logic [1:0] c_OP_RSVD  = 2'b11;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_START  = 2'd1;
    localparam logic [1:0] c_ST_RUN    = 2'd2;
    localparam logic [1:0] c_ST_FINISH = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              r_op;
    logic [CNTWIDTH-1:0]     r_words;
    logic                    r_err;
    logic [ADDRESSWIDTH-1:0] r_rd_base, r_rd_len, r_wr_base, r_wr_len;
    logic                    r_rd_done_seen, r_wr_done_seen;
    logic [CNTWIDTH-1:0]     r_words_moved;
    logic [CNTWIDTH-1:0]     r_pushed;

    logic [DATAWIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [c_PTRW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [c_PTRW:0]         r_count;

    logic                    w_accept, w_run, w_rd_used, w_wr_used;
    logic                    w_full, w_empty, w_src_room;
    logic                    w_rd_pull, w_wdata_ready, w_push, w_rvalid, w_wr_put, w_pop;
    logic                    w_all_done;
    logic [DATAWIDTH-1:0]    w_push_data;
    logic [ADDRESSWIDTH-1:0] w_len;

    assign w_accept   = (r_state == c_ST_IDLE) && bus.cmd_valid;
    assign w_run      = (r_state == c_ST_RUN);
    assign w_rd_used  = (r_op == c_OP_READ)  || (r_op == c_OP_COPY);
    assign w_wr_used  = (r_op == c_OP_WRITE) || (r_op == c_OP_COPY);
    assign w_full     = (r_count == c_FULL);
    assign w_empty    = (r_count == '0);
    assign w_src_room = (r_pushed != r_words);
    assign w_len      = ADDRESSWIDTH'(bus.cmd_words) * c_BPW_A;

    // Sources look only at the registered full flag, so the sink ready never
    // reaches a master strobe combinationally.
    assign w_rd_pull     = w_run && w_rd_used && bus.rd_data_available && !w_full && w_src_room;
    assign w_wdata_ready = w_run && (r_op == c_OP_WRITE) && !w_full && w_src_room;
    assign w_push        = w_rd_pull || (w_wdata_ready && bus.wdata_valid);
    assign w_push_data   = (r_op == c_OP_WRITE) ? bus.wdata : bus.rd_buffer_data;

    assign w_rvalid   = w_run && (r_op == c_OP_READ) && !w_empty;
    assign w_wr_put   = w_run && w_wr_used && !w_empty && !bus.wr_buffer_full;
    assign w_pop      = (w_rvalid && bus.rdata_ready) || w_wr_put;

    assign w_all_done = (r_words_moved == r_words) && w_empty
                     && (!w_rd_used || r_rd_done_seen)
                     && (!w_wr_used || r_wr_done_seen);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= c_ST_IDLE;
            r_op           <= c_OP_READ;
            r_words        <= '0;
            r_err          <= 1'b0;
            r_rd_base      <= '0;
            r_rd_len       <= '0;
            r_wr_base      <= '0;
            r_wr_len       <= '0;
            r_rd_done_seen <= 1'b0;
            r_wr_done_seen <= 1'b0;
            r_words_moved  <= '0;
            r_pushed       <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_op      <= bus.cmd_op;
                        r_words   <= bus.cmd_words;
                        r_rd_base <= bus.cmd_src;
                        r_wr_base <= bus.cmd_dst;
                        r_rd_len  <= w_len;
                        r_wr_len  <= w_len;
                        if ((bus.cmd_words == '0) || (bus.cmd_op == c_OP_RSVD)) begin
                            r_err   <= 1'b1;
                            r_state <= c_ST_FINISH;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= c_ST_START;
                        end
                    end
                end
                c_ST_START:  r_state <= c_ST_RUN;
                c_ST_RUN:    if (w_all_done) r_state <= c_ST_FINISH;
                default:     r_state <= c_ST_IDLE;
            endcase

            if (w_accept) begin
                r_words_moved  <= '0;
                r_pushed       <= '0;
                r_rd_done_seen <= 1'b0;
                r_wr_done_seen <= 1'b0;
            end else begin
                if (w_pop && (r_words_moved != r_words))
                    r_words_moved <= r_words_moved + c_W_ONE;
                if (w_push)
                    r_pushed <= r_pushed + c_W_ONE;
                if (bus.rd_done) r_rd_done_seen <= 1'b1;
                if (bus.wr_done) r_wr_done_seen <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_push_data;
    end

`ifdef AMM_XFER_FIXED_EN
    logic r_fixed;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_fixed <= 1'b0;
        else if (w_accept) r_fixed <= bus.cmd_fixed;
    end
    assign bus.rd_fixed_location = r_fixed;
    assign bus.wr_fixed_location = r_fixed;
`else
    logic w_unused_fixed;
    assign w_unused_fixed        = bus.cmd_fixed;
    assign bus.rd_fixed_location = 1'b0;
    assign bus.wr_fixed_location = 1'b0;
`endif

    assign bus.cmd_ready      = (r_state == c_ST_IDLE);
    assign bus.busy           = (r_state != c_ST_IDLE);
    assign bus.xfer_done      = (r_state == c_ST_FINISH) && !r_err;
    assign bus.xfer_error     = (r_state == c_ST_FINISH) &&  r_err;
    assign bus.rd_go          = (r_state == c_ST_START) && w_rd_used;
    assign bus.wr_go          = (r_state == c_ST_START) && w_wr_used;
    assign bus.rd_base        = r_rd_base;
    assign bus.rd_length      = r_rd_len;
    assign bus.wr_base        = r_wr_base;
    assign bus.wr_length      = r_wr_len;
    assign bus.rd_read_buffer = w_rd_pull;
    assign bus.wdata_ready    = w_wdata_ready;
    assign bus.rdata_valid    = w_rvalid;
    assign bus.rdata          = r_mem[r_rd_ptr];
    assign bus.wr_write_buffer = w_wr_put;
    assign bus.wr_buffer_data = r_mem[r_rd_ptr];
    assign bus.words_moved    = r_words_moved;

endmodule
`default_nettype wire

// File: tb/tb_amm_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_amm_xfer_sequencer
// Description : Directed testbench for amm_xfer_sequencer with behavioural
//               read/write master and user stream models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_amm_xfer_sequencer;
    localparam int AW = 28;
    localparam int DW = 32;
    localparam int FD = 16;
    localparam int CW = 16;
`ifdef AMM_XFER_FIXED_EN
    localparam logic c_FIX_EXP = 1'b1;
`else
    localparam logic c_FIX_EXP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    amm_xfer_sequencer_if #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .CNTWIDTH(CW)) bus ();
    amm_xfer_sequencer #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .FIFO_DEPTH(FD), .CNTWIDTH(CW))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int n_pass = 0, n_total = 0, cyc = 0, acc_cyc = 0;
    int rd_go_cnt, wr_go_cnt, rd_go_cyc, wr_go_cyc, done_cnt, err_cnt, done_cyc;
    int busy_cnt, rvalid_cnt, wready_bad, max_occ;
    bit rd_active, w_active, rready_on, wbf_toggle, rd_done_sent, wr_done_sent;
    int rd_next, rd_total, w_next, w_total, wbf_hold_until, wr_done_at, wr_done_min, wr_done_cyc;
    logic [31:0] rd_seed, w_seed;
    logic [31:0] wr_log[$];
    logic [31:0] rd_log[$];

    function automatic logic [31:0] pat(input logic [31:0] seed, input int i);
        return seed + 32'(i) * 32'h0001_0003;
    endfunction

    task automatic clear_model();
        rd_active = 0; rd_next = 0; rd_total = 0; rd_seed = 32'h0;
        w_active = 0; w_next = 0; w_total = 0; w_seed = 32'h0;
        rready_on = 0; wbf_toggle = 0; wbf_hold_until = 0;
        wr_done_at = 0; wr_done_min = 0; wr_done_cyc = -1;
        rd_done_sent = 0; wr_done_sent = 0;
        rd_go_cnt = 0; wr_go_cnt = 0; rd_go_cyc = -1; wr_go_cyc = -1;
        done_cnt = 0; err_cnt = 0; done_cyc = -1;
        busy_cnt = 0; rvalid_cnt = 0; wready_bad = 0; max_occ = 0;
        wr_log.delete(); rd_log.delete();
        bus.cmd_valid = 0; bus.cmd_op = 2'b00; bus.cmd_src = '0; bus.cmd_dst = '0;
        bus.cmd_words = '0; bus.cmd_fixed = 0;
    endtask

    task automatic drive_inputs();
        bus.rd_data_available = rd_active && (rd_next < rd_total);
        bus.rd_buffer_data    = pat(rd_seed, rd_next);
        bus.wdata_valid       = w_active && (w_next < w_total);
        bus.wdata             = pat(w_seed, w_next);
        bus.rdata_ready       = rready_on;
        bus.wr_buffer_full    = (cyc < wbf_hold_until) ? 1'b1 : (wbf_toggle && ((cyc / 3) % 2 == 1));
        bus.rd_done = 0;
        if (rd_active && !rd_done_sent && rd_next == rd_total) begin
            bus.rd_done = 1; rd_done_sent = 1;
        end
        bus.wr_done = 0;
        if (wr_done_at > 0 && !wr_done_sent && wr_log.size() >= wr_done_at && cyc >= wr_done_min) begin
            bus.wr_done = 1; wr_done_sent = 1; wr_done_cyc = cyc;
        end
    endtask

    // One clock of the master/user models: observe at +3, drive at +1.
    task automatic tick();
        int occ;
        #2;
        if (bus.rd_go) begin rd_go_cnt++; rd_go_cyc = cyc; rd_active = 1; end
        if (bus.wr_go) begin wr_go_cnt++; wr_go_cyc = cyc; end
        if (bus.xfer_done)  begin done_cnt++; done_cyc = cyc; end
        if (bus.xfer_error) begin err_cnt++;  done_cyc = cyc; end
        if (bus.busy) busy_cnt++;
        if (bus.rdata_valid) rvalid_cnt++;
        if (w_active) begin
            occ = w_next - wr_log.size();
            if (occ > max_occ) max_occ = occ;
            if (occ >= FD && bus.wdata_ready) wready_bad++;
        end
        if (bus.rd_read_buffer) rd_next++;
        if (bus.wr_write_buffer) wr_log.push_back(bus.wr_buffer_data);
        if (bus.rdata_valid && bus.rdata_ready) rd_log.push_back(bus.rdata);
        if (bus.wdata_valid && bus.wdata_ready) w_next++;
        @(posedge clk);
        cyc++;
        #1;
        drive_inputs();
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] src, input logic [AW-1:0] dst,
                         input logic [CW-1:0] words, input logic fixed);
        bus.cmd_op = op; bus.cmd_src = src; bus.cmd_dst = dst;
        bus.cmd_words = words; bus.cmd_fixed = fixed; bus.cmd_valid = 1;
        acc_cyc = cyc;
        tick();
        bus.cmd_valid = 0;
    endtask

    task automatic wait_finish(input int max_cyc);
        int start_n;
        start_n = done_cnt + err_cnt;
        for (int k = 0; k < max_cyc && (done_cnt + err_cnt) == start_n; k++) tick();
        if ((done_cnt + err_cnt) == start_n) begin
            n_total++;
            $display("FAIL finish_timeout: no done/error within %0d cycles (done=%0d err=%0d)", max_cyc, done_cnt, err_cnt);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [11:0] v;
        v = {bus.cmd_ready, bus.busy, bus.rd_go, bus.wr_go, bus.xfer_done, bus.xfer_error,
             bus.rdata_valid, bus.wdata_ready, bus.rd_read_buffer, bus.wr_write_buffer,
             bus.rd_fixed_location, bus.wr_fixed_location};
        n_total++;
        if (v !== 12'b1000_0000_0000) $display("FAIL %s_strobes: got %b expected %b", tag, v, 12'b1000_0000_0000);
        else n_pass++;
        n_total++;
        if ({bus.rd_base, bus.rd_length, bus.wr_base, bus.wr_length, bus.words_moved} !== '0)
            $display("FAIL %s_regs: got rb=%h rl=%h wb=%h wl=%h wm=%0d expected all 0", tag,
                     bus.rd_base, bus.rd_length, bus.wr_base, bus.wr_length, bus.words_moved);
        else n_pass++;
    endtask

    task automatic test_reset();
        clear_model();
        rd_active = 1; rd_total = 4; w_active = 1; w_total = 4;
        reset = 0;
        drive_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1;
        @(posedge clk); cyc++; #1;
        clear_model();
        drive_inputs();
    endtask

    task automatic test_read();
        clear_model();
        rd_total = 8; rd_seed = 32'hA500_0000; rready_on = 1;
        drive_inputs();
        issue(2'b00, 28'h100, 28'h0, 16'd8, 1'b0);
        #1;
        n_total++;
        if ({bus.rd_base, bus.rd_length} !== {28'h100, 28'd32})
            $display("FAIL read_base_len: got %h/%0d expected 100/32", bus.rd_base, bus.rd_length);
        else n_pass++;
        wait_finish(100);
        n_total++;
        if ({rd_go_cnt, rd_go_cyc - acc_cyc, wr_go_cnt} !== {32'd1, 32'd1, 32'd0})
            $display("FAIL read_go: got rd_go=%0d at +%0d wr_go=%0d expected 1 at +1, 0", rd_go_cnt, rd_go_cyc - acc_cyc, wr_go_cnt);
        else n_pass++;
        n_total++;
        if (rd_log.size() !== 8) $display("FAIL read_count: got %0d words expected 8", rd_log.size());
        else n_pass++;
        for (int i = 0; i < rd_log.size() && i < 8; i++) begin
            n_total++;
            if (rd_log[i] !== pat(32'hA500_0000, i)) $display("FAIL read_data[%0d]: got %h expected %h", i, rd_log[i], pat(32'hA500_0000, i));
            else n_pass++;
        end
        n_total++;
        if ({done_cnt, err_cnt, busy_cnt} !== {32'd1, 32'd0, 32'(done_cyc - acc_cyc)})
            $display("FAIL read_status: got done=%0d err=%0d busy_cycles=%0d expected 1,0,%0d", done_cnt, err_cnt, busy_cnt, done_cyc - acc_cyc);
        else n_pass++;
        #1;
        n_total++;
        if ({bus.cmd_ready, bus.words_moved} !== {1'b1, 16'd8})
            $display("FAIL read_after: got cmd_ready=%b words_moved=%0d expected 1,8", bus.cmd_ready, bus.words_moved);
        else n_pass++;
    endtask

    task automatic test_write();
        clear_model();
        w_active = 1; w_total = 20; w_seed = 32'h5A00_0000;
        wbf_hold_until = cyc + 24; wbf_toggle = 1;
        wr_done_at = 20; wr_done_min = cyc + 90;
        drive_inputs();
        issue(2'b01, 28'h0, 28'h200, 16'd20, 1'b0);
        #1;
        n_total++;
        if ({bus.wr_base, bus.wr_length} !== {28'h200, 28'd80})
            $display("FAIL write_base_len: got %h/%0d expected 200/80", bus.wr_base, bus.wr_length);
        else n_pass++;
        wait_finish(300);
        n_total++;
        if ({wr_go_cnt, wr_go_cyc - acc_cyc, rd_go_cnt} !== {32'd1, 32'd1, 32'd0})
            $display("FAIL write_go: got wr_go=%0d at +%0d rd_go=%0d expected 1 at +1, 0", wr_go_cnt, wr_go_cyc - acc_cyc, rd_go_cnt);
        else n_pass++;
        n_total++;
        if (wr_log.size() !== 20) $display("FAIL write_count: got %0d words expected 20", wr_log.size());
        else n_pass++;
        for (int i = 0; i < wr_log.size() && i < 20; i++) begin
            n_total++;
            if (wr_log[i] !== pat(32'h5A00_0000, i)) $display("FAIL write_data[%0d]: got %h expected %h", i, wr_log[i], pat(32'h5A00_0000, i));
            else n_pass++;
        end
        n_total++;
        if ({max_occ, wready_bad} !== {32'd16, 32'd0})
            $display("FAIL write_backpressure: got max_fill=%0d ready_while_full=%0d expected 16,0", max_occ, wready_bad);
        else n_pass++;
        n_total++;
        if (!(wr_done_sent && done_cnt == 1 && done_cyc > wr_done_cyc))
            $display("FAIL write_done_order: got done=%0d at %0d wr_done at %0d expected done after wr_done", done_cnt, done_cyc, wr_done_cyc);
        else n_pass++;
        #1;
        n_total++;
        if (bus.words_moved !== 16'd20) $display("FAIL write_words_moved: got %0d expected 20", bus.words_moved);
        else n_pass++;
    endtask

    task automatic test_copy();
        clear_model();
        rd_total = 40; rd_seed = 32'h3C00_0000; wbf_toggle = 1;
        wr_done_at = 1; wr_done_min = 0;
        drive_inputs();
        issue(2'b10, 28'h1000, 28'h3000, 16'd40, 1'b0);
        wait_finish(400);
        n_total++;
        if ({rd_go_cnt, wr_go_cnt, rd_go_cyc - acc_cyc, wr_go_cyc - acc_cyc} !== {32'd1, 32'd1, 32'd1, 32'd1})
            $display("FAIL copy_go: got rd=%0d@+%0d wr=%0d@+%0d expected 1@+1 both", rd_go_cnt, rd_go_cyc - acc_cyc, wr_go_cnt, wr_go_cyc - acc_cyc);
        else n_pass++;
        n_total++;
        if (wr_log.size() !== 40) $display("FAIL copy_count: got %0d words expected 40", wr_log.size());
        else n_pass++;
        for (int i = 0; i < wr_log.size() && i < 40; i++) begin
            n_total++;
            if (wr_log[i] !== pat(32'h3C00_0000, i)) $display("FAIL copy_data[%0d]: got %h expected %h", i, wr_log[i], pat(32'h3C00_0000, i));
            else n_pass++;
        end
        n_total++;
        if (!(done_cnt == 1 && err_cnt == 0 && wr_done_cyc >= 0 && done_cyc > wr_done_cyc + 10 && rvalid_cnt == 0))
            $display("FAIL copy_status: got done=%0d err=%0d wr_done@%0d done@%0d rvalid=%0d expected drained completion", done_cnt, err_cnt, wr_done_cyc, done_cyc, rvalid_cnt);
        else n_pass++;
        #1;
        n_total++;
        if (bus.words_moved !== 16'd40) $display("FAIL copy_words_moved: got %0d expected 40", bus.words_moved);
        else n_pass++;
    endtask

    task automatic test_error();
        for (int t = 0; t < 2; t++) begin
            clear_model();
            rd_total = 5; rready_on = 1;
            drive_inputs();
            if (t == 0) issue(2'b00, 28'h40, 28'h80, 16'd0, 1'b0);
            else        issue(2'b11, 28'h40, 28'h80, 16'd5, 1'b0);
            wait_finish(10);
            n_total++;
            if ({err_cnt, done_cnt, rd_go_cnt + wr_go_cnt, busy_cnt} !== {32'd1, 32'd0, 32'd0, 32'd1})
                $display("FAIL error_%0d: got err=%0d done=%0d go=%0d busy=%0d expected 1,0,0,1", t, err_cnt, done_cnt, rd_go_cnt + wr_go_cnt, busy_cnt);
            else n_pass++;
            #1;
            n_total++;
            if ({bus.words_moved, bus.cmd_ready} !== {16'd0, 1'b1})
                $display("FAIL error_%0d_after: got words_moved=%0d cmd_ready=%b expected 0,1", t, bus.words_moved, bus.cmd_ready);
            else n_pass++;
        end
    endtask

    task automatic test_fixed();
        clear_model();
        rd_total = 1; rd_seed = 32'h7700_0000; rready_on = 1;
        drive_inputs();
        issue(2'b00, 28'h600, 28'h0, 16'd1, 1'b1);
        #1;
        n_total++;
        if ({bus.rd_fixed_location, bus.wr_fixed_location} !== {c_FIX_EXP, c_FIX_EXP})
            $display("FAIL fixed_flags: got %b%b expected %b%b", bus.rd_fixed_location, bus.wr_fixed_location, c_FIX_EXP, c_FIX_EXP);
        else n_pass++;
        wait_finish(50);
        n_total++;
        if ({done_cnt, rd_log.size()} !== {32'd1, 32'd1})
            $display("FAIL fixed_done: got done=%0d words=%0d expected 1,1", done_cnt, rd_log.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int k;
        clear_model();
        rd_total = 40; rd_seed = 32'h1100_0000; wbf_hold_until = cyc + 1000;
        drive_inputs();
        issue(2'b10, 28'h2000, 28'h4000, 16'd40, 1'b0);
        for (k = 0; k < 50 && rd_next != 5; k++) tick();
        n_total++;
        if (rd_next != 5) $display("FAIL midreset_fill: got %0d buffered words expected 5", rd_next);
        else n_pass++;
        #2;
        reset = 0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); cyc++; #1;
        reset = 1;
        clear_model();
        drive_inputs();
        rd_total = 4; rd_seed = 32'hBE00_0000; rready_on = 1;
        drive_inputs();
        issue(2'b00, 28'h500, 28'h0, 16'd4, 1'b0);
        wait_finish(60);
        n_total++;
        if ({done_cnt, rd_log.size()} !== {32'd1, 32'd4})
            $display("FAIL midreset_read: got done=%0d words=%0d expected 1,4", done_cnt, rd_log.size());
        else n_pass++;
        for (int i = 0; i < rd_log.size() && i < 4; i++) begin
            n_total++;
            if (rd_log[i] !== pat(32'hBE00_0000, i)) $display("FAIL midreset_data[%0d]: got %h expected %h", i, rd_log[i], pat(32'hBE00_0000, i));
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_copy();
        test_error();
        test_fixed();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit, %0d/%0d passed", n_pass, n_total);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
